// File: rtl/mem_access_unit_if.sv
// Data-bus interface between the memory access unit (master) and memory (slave).
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory access stage: converts Mem_rd/Mem_wr levels into one bus transaction,
// steers store lanes, extends load data and returns a one-cycle MFC pulse.
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    input  logic [2:0]            funct3,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic                  mfc,
    output logic [31:0]           rdata,
    output logic                  misalign,
    output logic                  bus_err,
    mem_access_unit_if.master     bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    // A zero TIMEOUT would give a zero-width counter; keep one bit in that case.
    localparam int             CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  TO_VAL = CW'(TIMEOUT);

    logic [1:0]    state_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    f3_reg;
    logic [1:0]    off_reg;
    logic          mfc_reg, misalign_reg, err_reg;
    logic [31:0]   rdata_reg;
    logic          req_reg, we_reg;
    logic [31:0]   addr_reg, wdata_reg;
    logic [3:0]    be_reg;

    logic          illegal_next, misal_next;
    logic [3:0]    be_next;
    logic [31:0]   wdata_next;
    logic [31:0]   load_val;
    logic [CW-1:0] cnt_inc;
    logic [7:0]    rd_lane [4];

    // Split the raw read word into its four byte lanes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_lane[gi] = bus.bus_rdata[gi*8 +: 8];
        end
    endgenerate

    assign cnt_inc = cnt_reg + 1'b1;

    // Decode the incoming request: legality, alignment, lane enables and steered data.
    always_comb begin
        illegal_next = 1'b0;
        misal_next   = 1'b0;
        be_next      = 4'hF;
        wdata_next   = wdata;
        if (mem_wr)
            illegal_next = funct3[2] | (funct3[1:0] == 2'b11);
        else
            illegal_next = (funct3[1:0] == 2'b11) | (funct3 == 3'b110);
        if (!illegal_next)
            misal_next = ((funct3[1:0] == 2'b01) & addr[0]) |
                         ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
        case (funct3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_next    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{wdata[15:0]}};
            end
            default: begin
                be_next    = 4'hF;
                wdata_next = wdata;
            end
        endcase
    end

    // Extract and extend the load result from the captured size and byte offset.
    always_comb begin
        load_val = bus.bus_rdata;
        case (f3_reg)
            3'b000: load_val = {{24{rd_lane[off_reg][7]}}, rd_lane[off_reg]};
            3'b100: load_val = {24'h0, rd_lane[off_reg]};
            3'b001: load_val = off_reg[1] ? {{16{bus.bus_rdata[31]}}, bus.bus_rdata[31:16]}
                                          : {{16{bus.bus_rdata[15]}}, bus.bus_rdata[15:0]};
            3'b101: load_val = off_reg[1] ? {16'h0, bus.bus_rdata[31:16]}
                                          : {16'h0, bus.bus_rdata[15:0]};
            default: load_val = bus.bus_rdata;
        endcase
    end

    // Access FSM with registered bus signals, completion pulse and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            f3_reg       <= 3'b000;
            off_reg      <= 2'b00;
            mfc_reg      <= 1'b0;
            misalign_reg <= 1'b0;
            err_reg      <= 1'b0;
            rdata_reg    <= 32'h0;
            req_reg      <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= 32'h0;
            be_reg       <= 4'h0;
            wdata_reg    <= 32'h0;
        end else begin
            mfc_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (mem_rd | mem_wr) begin
                        f3_reg       <= funct3;
                        off_reg      <= addr[1:0];
                        misalign_reg <= misal_next;
                        err_reg      <= illegal_next;
                        cnt_reg      <= '0;
                        if (illegal_next | misal_next) begin
                            // Rejected before any bus cycle is issued.
                            mfc_reg   <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            req_reg   <= 1'b1;
                            we_reg    <= mem_wr;
                            addr_reg  <= {addr[31:2], 2'b00};
                            be_reg    <= be_next;
                            wdata_reg <= wdata_next;
                            state_reg <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.bus_ack) begin
                        req_reg   <= 1'b0;
                        if (!we_reg)
                            rdata_reg <= load_val;
                        mfc_reg   <= 1'b1;
                        state_reg <= S_DONE;
                    end else if ((TIMEOUT != 0) && (cnt_inc == TO_VAL)) begin
                        req_reg   <= 1'b0;
                        err_reg   <= 1'b1;
                        mfc_reg   <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                S_DONE: begin
                    state_reg <= S_HOLD;
                end
                default: begin
                    // Wait for the control word to drop so a held level cannot re-trigger.
                    if (!(mem_rd | mem_wr))
                        state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign mfc           = mfc_reg;
    assign rdata         = rdata_reg;
    assign misalign      = misalign_reg;
    assign bus_err       = err_reg;
    assign bus.bus_req   = req_reg;
    assign bus.bus_we    = we_reg;
    assign bus.bus_addr  = addr_reg;
    assign bus.bus_be    = be_reg;
    assign bus.bus_wdata = wdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table plus scoreboard queue,
// followed by hand-written held-level, reset-mid-access and stray-ack sequences.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        mfc;
    logic [31:0] rdata;
    logic        misalign;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    mem_access_unit_if bus_if ();

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .mfc      (mfc),
        .rdata    (rdata),
        .misalign (misalign),
        .bus_err  (bus_err),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          wr;
        bit          both;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brd;
        int          dly;      // REQ cycles before ack; 255 = never
        logic [3:0]  be;
        logic [31:0] bwd;
        logic [31:0] rd;
        bit          mis;
        bit          err;
        int          lat;      // cycles from request edge to mfc
        int          reqc;     // cycles bus_req is observed high
    } vec_t;

    vec_t vecs [15];
    vec_t sbq [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   lat;
        int   reqc;
        bit   got;
        vec_t e;
        @(negedge clk);
        funct3 = v.f3;
        addr   = v.addr;
        wdata  = v.wdata;
        mem_wr = v.wr;
        mem_rd = !v.wr || v.both;
        bus_if.bus_rdata = v.brd;
        sbq.push_back(v);
        lat  = 0;
        reqc = 0;
        got  = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            lat++;
            if (bus_if.bus_req) begin
                if (reqc == 0) begin
                    check({v.name, "_addr"}, bus_if.bus_addr, {v.addr[31:2], 2'b00});
                    check({v.name, "_be"}, {28'h0, bus_if.bus_be}, {28'h0, v.be});
                    check({v.name, "_we"}, {31'h0, bus_if.bus_we}, {31'h0, v.wr});
                    if (v.wr)
                        check({v.name, "_wdata"}, bus_if.bus_wdata, v.bwd);
                end
                bus_if.bus_ack = (reqc == v.dly);
                reqc++;
            end else begin
                bus_if.bus_ack = 1'b0;
            end
            if (mfc) begin
                got = 1'b1;
                e = sbq.pop_front();
                check({e.name, "_misalign"}, {31'h0, misalign}, {31'h0, e.mis});
                check({e.name, "_bus_err"}, {31'h0, bus_err}, {31'h0, e.err});
                check({e.name, "_rdata"}, rdata, e.rd);
                check({e.name, "_latency"}, lat, e.lat);
                check({e.name, "_req_cycles"}, reqc, e.reqc);
            end
        end
        if (!got) begin
            check({v.name, "_mfc_seen"}, 32'h0, 32'h1);
            void'(sbq.pop_front());
        end
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        bus_if.bus_ack = 1'b0;
        for (int q = 0; q < 2; q++) begin
            @(negedge clk);
            check({v.name, "_quiet"}, {30'h0, mfc, bus_if.bus_req}, 32'h0);
        end
        $display("txn %-8s f3=%b addr=%h -> rdata=%h misalign=%0b bus_err=%0b lat=%0d",
                 v.name, v.f3, v.addr, rdata, misalign, bus_err, lat);
    endtask

    initial begin
        int reqn;
        int mfcn;
        bit seen;

        vecs[0]  = '{"LW",      0, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0,   4'hF, 32'h0,        32'hDEADBEEF, 0, 0, 2, 1};
        vecs[1]  = '{"LB",      0, 0, 3'b000, 32'h103, 32'h0,        32'h80000000, 0,   4'h8, 32'h0,        32'hFFFFFF80, 0, 0, 2, 1};
        vecs[2]  = '{"LBU",     0, 0, 3'b100, 32'h103, 32'h0,        32'h80000000, 0,   4'h8, 32'h0,        32'h00000080, 0, 0, 2, 1};
        vecs[3]  = '{"LH",      0, 0, 3'b001, 32'h102, 32'h0,        32'h80011234, 0,   4'hC, 32'h0,        32'hFFFF8001, 0, 0, 2, 1};
        vecs[4]  = '{"LHU",     0, 0, 3'b101, 32'h100, 32'h0,        32'h80011234, 2,   4'h3, 32'h0,        32'h00001234, 0, 0, 4, 3};
        vecs[5]  = '{"SB",      1, 0, 3'b000, 32'h201, 32'h12345678, 32'h0,        0,   4'h2, 32'h78787878, 32'h00001234, 0, 0, 2, 1};
        vecs[6]  = '{"SH",      1, 0, 3'b001, 32'h202, 32'h12345678, 32'h0,        0,   4'hC, 32'h56785678, 32'h00001234, 0, 0, 2, 1};
        vecs[7]  = '{"SW",      1, 0, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0,        1,   4'hF, 32'hCAFEF00D, 32'h00001234, 0, 0, 3, 2};
        vecs[8]  = '{"LW_mis",  0, 0, 3'b010, 32'h102, 32'h0,        32'h0,        0,   4'h0, 32'h0,        32'h00001234, 1, 0, 1, 0};
        vecs[9]  = '{"SH_mis",  1, 0, 3'b001, 32'h101, 32'h0,        32'h0,        0,   4'h0, 32'h0,        32'h00001234, 1, 0, 1, 0};
        vecs[10] = '{"LD011",   0, 0, 3'b011, 32'h100, 32'h0,        32'h0,        0,   4'h0, 32'h0,        32'h00001234, 0, 1, 1, 0};
        vecs[11] = '{"ST100",   1, 0, 3'b100, 32'h200, 32'h0,        32'h0,        0,   4'h0, 32'h0,        32'h00001234, 0, 1, 1, 0};
        vecs[12] = '{"LW_tmo",  0, 0, 3'b010, 32'h300, 32'h0,        32'h55555555, 255, 4'hF, 32'h0,        32'h00001234, 0, 1, 5, 4};
        vecs[13] = '{"LB_l2",   0, 0, 3'b000, 32'h302, 32'h0,        32'h007F0000, 0,   4'h4, 32'h0,        32'h0000007F, 0, 0, 2, 1};
        vecs[14] = '{"RDWR",    1, 1, 3'b000, 32'h200, 32'h000000AB, 32'h0,        0,   4'h1, 32'hABABABAB, 32'h0000007F, 0, 0, 2, 1};

        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 32'h0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_outs", {28'h0, mfc, misalign, bus_err, bus_if.bus_req}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_addr", bus_if.bus_addr, 32'h0);
        check("rst_be_we", {27'h0, bus_if.bus_we, bus_if.bus_be}, 32'h0);
        check("rst_wdata", bus_if.bus_wdata, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++)
            run_vec(vecs[i]);
        check("sb_empty", sbq.size(), 32'h0);

        // Level held for several cycles must produce one access only.
        @(negedge clk);
        funct3 = 3'b010; addr = 32'h100; mem_rd = 1'b1;
        bus_if.bus_rdata = 32'h11223344;
        reqn = 0; mfcn = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus_if.bus_req) reqn++;
            if (mfc) mfcn++;
            bus_if.bus_ack = bus_if.bus_req;
        end
        mem_rd = 1'b0;
        bus_if.bus_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus_if.bus_req) reqn++;
            if (mfc) mfcn++;
        end
        check("hold_req_cycles", reqn, 32'd1);
        check("hold_mfc_count", mfcn, 32'd1);
        check("hold_rdata", rdata, 32'h11223344);
        $display("txn hold     req_cycles=%0d mfc_pulses=%0d rdata=%h", reqn, mfcn, rdata);

        // Reset while the bus request is outstanding.
        @(negedge clk);
        funct3 = 3'b010; addr = 32'h400; mem_rd = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            seen = bus_if.bus_req;
        end
        check("rstmid_req_seen", {31'h0, seen}, 32'h1);
        rst = 1'b1;
        mem_rd = 1'b0;
        @(negedge clk);
        check("rstmid_outs", {28'h0, mfc, misalign, bus_err, bus_if.bus_req}, 32'h0);
        check("rstmid_rdata", rdata, 32'h0);
        check("rstmid_addr", bus_if.bus_addr, 32'h0);
        check("rstmid_be", {28'h0, bus_if.bus_be}, 32'h0);
        rst = 1'b0;
        mfcn = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (mfc) mfcn++;
        end
        check("rstmid_no_mfc", mfcn, 32'd0);
        $display("txn rst_mid  bus_req=%0b rdata=%h mfc_after=%0d", bus_if.bus_req, rdata, mfcn);

        // Ack outside REQ is ignored.
        bus_if.bus_ack = 1'b1;
        mfcn = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mfc || bus_if.bus_req) mfcn++;
        end
        bus_if.bus_ack = 1'b0;
        check("idle_ack_ignored", mfcn, 32'd0);
        $display("txn idle_ack activity=%0d", mfcn);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory access stage of the multicycle RISC-V core, directly downstream of the control generator. It turns the Mem_rd/Mem_wr strobes of the MEM step into one request on the data bus. It performs byte-lane steering for stores and sign/zero extension for loads, then returns a one-cycle memory-function-complete (MFC) pulse that releases the control generator's WMFC wait. Misaligned, illegal-size and timed-out accesses complete with an error flag, never a hang.

## Interface
- TIMEOUT, 255, max cycles spent waiting for bus_ack; 0 disables the timeout
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- mem_rd  input  1  load request level from control word
- mem_wr  input  1  store request level from control word; wins if mem_rd is also high
- funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU load only)
- addr  input  32  effective byte address
- wdata  input  32  store data, right-aligned
- mfc  output  1  one-cycle completion pulse
- rdata  output  32  extended load data, held until next load completes
- misalign  output  1  valid with mfc: address not aligned to size
- bus_err  output  1  valid with mfc: illegal funct3 or timeout
- bus_req  output  1  bus request, held until ack
- bus_we  output  1  1 = write
- bus_addr  output  32  word address ({addr[31:2],2'b00})
- bus_be  output  4  byte enables
- bus_wdata  output  32  lane-steered store data
- bus_ack  input  1  bus completion; bus_rdata valid when high
- bus_rdata  input  32  raw read word

## Operation
- FSM states: IDLE, REQ, DONE, HOLD. All outputs are registered.
- IDLE: on mem_rd|mem_wr, capture funct3, addr[1:0], direction and steered data.
  - If illegal funct3 (store 011–111; load 011, 110, 111) or misaligned (H with addr[0]=1; W with addr[1:0]≠0): go to DONE with the matching flag. No bus cycle is issued.
  - Otherwise assert bus_req and go to REQ.
- REQ: bus_addr, bus_we, bus_be and bus_wdata stay stable.
  - On bus_ack: drop bus_req; on a load, update rdata; go to DONE.
  - Wait counter (width clog2(TIMEOUT+1)) increments each REQ cycle without ack. When it reaches TIMEOUT: drop bus_req, set bus_err, go to DONE, rdata unchanged.
- DONE: mfc=1 for exactly one cycle, with misalign/bus_err valid. Then go to HOLD.
- HOLD: wait until mem_rd=mem_wr=0, then go to IDLE. A level held across several control states therefore never starts a second access.
- Store steering:
  - SB: be=4'b0001<<addr[1:0]; byte replicated on all 4 lanes.
  - SH: be=0011 (addr[1]=0) or 1100; halfword replicated.
  - SW: be=1111.
- Load extraction: byte lane addr[1:0] or half lane addr[1]. B/H sign-extend to 32 bits; BU/HU zero-extend; W passes through.
- bus_ack outside REQ is ignored.
- Flags are cleared when the next access starts.

## Timing
- Reset: state IDLE; mfc, misalign, bus_err, bus_req, bus_we = 0; bus_addr, bus_be, bus_wdata, rdata = 0; counter = 0.
- Request seen in IDLE at cycle N → bus_req high at N+1.
- bus_ack high at cycle M → bus_req low and mfc high at M+1, rdata valid at M+1.
- Minimum latency: ack at N+1 → mfc at N+2.
- Error without bus cycle: request at N → mfc plus flag at N+1.
- Timeout: bus_req is high for TIMEOUT cycles; mfc plus bus_err follows on the next cycle.
- rst mid-access: bus_req drops at the next edge, no mfc is issued, rdata is cleared.

## Test plan
- LW, addr=0x100, bus_rdata=0xDEADBEEF, ack in first REQ cycle → bus_be=1111, bus_addr=0x100, mfc 2 cycles after request, rdata=0xDEADBEEF.
- LB addr=0x103 then LBU addr=0x103, bus_rdata=0x80000000 → rdata=0xFFFFFF80, then 0x00000080. LH addr=0x102, rdata 0x8001xxxx → 0xFFFF8001.
- SB addr=0x201, wdata=0x12345678 → bus_we=1, bus_be=0010, bus_wdata=0x78787878. SH addr=0x202 → be=1100, bus_wdata=0x56785678.
- LW addr=0x102 and SH addr=0x101 → no bus_req; mfc with misalign=1 one cycle after request. Load funct3=011 → mfc with bus_err=1.
- TIMEOUT=4, ack never asserted → bus_req high 4 cycles, then mfc with bus_err=1, rdata unchanged.
- mem_rd held high 6 cycles → exactly one bus_req and one mfc. Also: assert rst during REQ → bus_req 0 next cycle, no mfc, all outputs at reset values.
